// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order micro-op queue that issues up to two ops per cycle to the two-lane ExecuteUnit
// Build option: define ISSUE_DUAL_EN for dual issue; leave it undefined for single-issue debug mode.
module issue_scheduler #(
    parameter int DEPTH = 8,
    parameter int UOP_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              enq_valid,
    input  logic [UOP_W-1:0]        enq_uop0,
    input  logic [UOP_W-1:0]        enq_uop1,
    output logic                    enq_ready,
    input  logic                    flush,
    input  logic                    stall,
    output logic [1:0]              iss_valid,
    output logic [UOP_W-1:0]        iss_uop0,
    output logic [UOP_W-1:0]        iss_uop1,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UOP_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d, tail1;
    logic [CW-1:0]    cnt_q, cnt_d, enq_n, deq_n;
    logic             enq_ok, sel0, sel1;
    logic [UOP_W-1:0] h0;
    logic             v0_q, v0_d;
    logic [UOP_W-1:0] u0_q, u0_d;

    assign enq_ready = cnt_q <= CW'(DEPTH - 2);
    assign occupancy = cnt_q;
    assign tail1     = tail_q + AW'(1);
    assign h0        = mem_q[head_q];
    assign sel0      = cnt_q != '0;

`ifdef ISSUE_DUAL_EN
    logic [AW-1:0]    head1;
    logic [UOP_W-1:0] h1;
    logic             raw, ctl2;
    logic             v1_q, v1_d;
    logic [UOP_W-1:0] u1_q, u1_d;

    assign head1 = head_q + AW'(1);
    assign h1    = mem_q[head1];
    // Younger op reading a register the head writes (x0 excluded) must wait a cycle.
    assign raw   = h0[44] && h0[35:32] != 4'd0 && (h0[35:32] == h1[39:36] || h0[35:32] == h1[43:40]);
    assign ctl2  = h0[45] && h1[45];
    assign sel1  = cnt_q >= CW'(2) && !raw && !ctl2;

    // Lane 1 issue register: cleared on flush, held on stall, else loaded from the selection.
    always_comb begin
        v1_d = flush ? 1'b0 : (stall ? v1_q : sel1);
        u1_d = (flush || stall) ? u1_q : (sel1 ? h1 : '0);
    end

    // Lane 1 issue state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            u1_q <= '0;
        end else begin
            v1_q <= v1_d;
            u1_q <= u1_d;
        end
    end

    assign iss_valid = {v1_q, v0_q};
    assign iss_uop1  = u1_q;
`else
    assign sel1      = 1'b0;
    assign iss_valid = {1'b0, v0_q};
    assign iss_uop1  = '0;
`endif

    assign iss_uop0 = u0_q;

    // Queue bookkeeping and lane 0 issue register; flush discards the whole queue and any same-cycle enqueue.
    always_comb begin
        enq_ok = enq_ready && !flush;
        enq_n  = enq_ok ? CW'(enq_valid[0]) + CW'(enq_valid[1]) : '0;
        deq_n  = (stall || flush) ? '0 : CW'(sel0) + CW'(sel1);
        tail_d = tail_q + enq_n[AW-1:0];
        head_d = flush ? tail_q : head_q + deq_n[AW-1:0];
        cnt_d  = flush ? '0 : cnt_q + enq_n - deq_n;
        v0_d   = flush ? 1'b0 : (stall ? v0_q : sel0);
        u0_d   = (flush || stall) ? u0_q : (sel0 ? h0 : '0);
    end

    // Pointers, occupancy and lane 0 issue state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            v0_q   <= 1'b0;
            u0_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            v0_q   <= v0_d;
            u0_q   <= u0_d;
        end
    end

    // Queue storage: slot 0 lands at tail, slot 1 behind it (or at tail when it enqueues alone).
    always_ff @(posedge clk) begin
        if (enq_n != '0) begin
            if (enq_valid[0]) mem_q[tail_q] <= enq_uop0;
            if (enq_valid[1]) mem_q[enq_valid[0] ? tail1 : tail_q] <= enq_uop1;
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed checks of queueing, pairing rules, stall, flush and async reset
module tb_issue_scheduler;
`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  enq_valid = 2'b00;
    logic [63:0] enq_uop0 = '0, enq_uop1 = '0;
    logic        flush = 1'b0, stall = 1'b0;
    logic        enq_ready;
    logic [1:0]  iss_valid;
    logic [63:0] iss_uop0, iss_uop1;
    logic [3:0]  occupancy;
    int n_cmp = 0;
    int n_err = 0;

    issue_scheduler #(.DEPTH(8), .UOP_W(64)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_uop0(enq_uop0), .enq_uop1(enq_uop1),
        .enq_ready(enq_ready), .flush(flush), .stall(stall), .iss_valid(iss_valid),
        .iss_uop0(iss_uop0), .iss_uop1(iss_uop1), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int pc, input int rd, input int rs1, input int rs2, input bit wr, input bit ctl);
        logic [31:0] p;
        logic [31:0] d, s1, s2;
        p = pc; d = rd; s1 = rs1; s2 = rs2;
        return {p[17:0] ^ 18'h2A5A5, ctl, wr, s2[3:0], s1[3:0], d[3:0], p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b);
        enq_valid = v; enq_uop0 = a; enq_uop1 = b;
        step();
        enq_valid = 2'b00;
    endtask

    task automatic pair_test(input string tag, input logic [63:0] a, input logic [63:0] b, input bit split);
        bit two;
        two = DUAL && !split;
        enq(2'b11, a, b);
        chk({tag, " enq occ"}, 64'(occupancy), 2);
        chk({tag, " latency"}, 64'(iss_valid), 0);
        step();
        chk({tag, " c1 valid"}, 64'(iss_valid), two ? 3 : 1);
        chk({tag, " c1 uop0"}, iss_uop0, a);
        if (two) chk({tag, " c1 uop1"}, iss_uop1, b);
        chk({tag, " c1 occ"}, 64'(occupancy), two ? 0 : 1);
        if (!two) begin
            step();
            chk({tag, " c2 valid"}, 64'(iss_valid), 1);
            chk({tag, " c2 uop0"}, iss_uop0, b);
            chk({tag, " c2 occ"}, 64'(occupancy), 0);
        end
        step();
        chk({tag, " idle valid"}, 64'(iss_valid), 0);
    endtask

    initial begin
        step();
        chk("rst valid", 64'(iss_valid), 0);
        chk("rst occ", 64'(occupancy), 0);
        chk("rst ready", 64'(enq_ready), 1);
        chk("rst uop0", iss_uop0, 0);
        chk("rst uop1", iss_uop1, 0);
        rst = 1'b0;
        step();

        pair_test("indep", mk(32'h0, 1, 3, 4, 1, 0), mk(32'h4, 2, 5, 6, 1, 0), 0);
        pair_test("raw rs1", mk(32'h0, 5, 1, 2, 1, 0), mk(32'h4, 6, 5, 7, 1, 0), 1);
        pair_test("rd0", mk(32'h0, 0, 1, 2, 1, 0), mk(32'h4, 6, 0, 0, 1, 0), 0);
        pair_test("raw rs2", mk(32'h10, 3, 1, 2, 1, 0), mk(32'h14, 6, 8, 3, 1, 0), 1);
        pair_test("no wr", mk(32'h20, 4, 1, 2, 0, 0), mk(32'h24, 6, 4, 4, 1, 0), 0);
        pair_test("ctrl pair", mk(32'h8, 0, 1, 2, 0, 1), mk(32'hC, 0, 3, 4, 0, 1), 1);
        pair_test("op+ctrl", mk(32'h30, 7, 1, 2, 1, 0), mk(32'h34, 0, 3, 4, 0, 1), 0);
        pair_test("ctrl+op", mk(32'h38, 0, 1, 2, 0, 1), mk(32'h3C, 9, 3, 4, 1, 0), 0);

        enq(2'b10, mk(32'hDEAD, 1, 1, 1, 1, 0), mk(32'h50, 2, 3, 4, 1, 0));
        chk("slot1 occ", 64'(occupancy), 1);
        step();
        chk("slot1 valid", 64'(iss_valid), 1);
        chk("slot1 uop0", iss_uop0, mk(32'h50, 2, 3, 4, 1, 0));
        chk("slot1 occ0", 64'(occupancy), 0);
        step();
        chk("slot1 idle", 64'(iss_valid), 0);

        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq(2'b11, mk(256 + 8 * i, 0, 1, 2, 0, 0), mk(260 + 8 * i, 0, 1, 2, 0, 0));
            chk("fill occ", 64'(occupancy), 64'((i + 1) * 2));
            chk("fill ready", 64'(enq_ready), (i < 3) ? 1 : 0);
            chk("fill hold", 64'(iss_valid), 0);
        end
        enq(2'b11, mk(32'h200, 0, 1, 2, 0, 0), mk(32'h204, 0, 1, 2, 0, 0));
        chk("full drop occ", 64'(occupancy), 8);
        stall = 1'b0;
        for (int k = 0; k < (DUAL ? 4 : 8); k++) begin
            step();
            chk("drain valid", 64'(iss_valid), DUAL ? 3 : 1);
            chk("drain uop0", iss_uop0, mk(DUAL ? 256 + 8 * k : 256 + 4 * k, 0, 1, 2, 0, 0));
            chk("drain uop1", iss_uop1, DUAL ? mk(260 + 8 * k, 0, 1, 2, 0, 0) : 64'h0);
            chk("drain occ", 64'(occupancy), 64'(8 - (DUAL ? 2 : 1) * (k + 1)));
            chk("drain ready", 64'(enq_ready), (8 - (DUAL ? 2 : 1) * (k + 1) <= 6) ? 1 : 0);
        end
        step();
        chk("drain end valid", 64'(iss_valid), 0);
        chk("drain end occ", 64'(occupancy), 0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) enq(2'b11, mk(32'h300 + 8 * i, 0, 1, 2, 0, 0), mk(32'h304 + 8 * i, 0, 1, 2, 0, 0));
        chk("pre flush occ", 64'(occupancy), 6);
        stall = 1'b0;
        enq(2'b11, mk(32'h400, 0, 1, 2, 0, 0), mk(32'h404, 0, 1, 2, 0, 0));
        chk("pre flush valid", 64'(iss_valid), DUAL ? 3 : 1);
        chk("pre flush uop0", iss_uop0, mk(32'h300, 0, 1, 2, 0, 0));
        chk("pre flush occ2", 64'(occupancy), DUAL ? 6 : 7);
        flush = 1'b1;
        enq(2'b11, mk(32'h500, 0, 1, 2, 0, 0), mk(32'h504, 0, 1, 2, 0, 0));
        flush = 1'b0;
        chk("flush occ", 64'(occupancy), 0);
        chk("flush valid", 64'(iss_valid), 0);
        chk("flush ready", 64'(enq_ready), 1);
        step();
        chk("flush after valid", 64'(iss_valid), 0);
        chk("flush after occ", 64'(occupancy), 0);
        pair_test("post flush", mk(32'h600, 1, 2, 3, 1, 0), mk(32'h604, 2, 4, 5, 1, 0), 0);

        enq(2'b11, mk(32'h700, 0, 1, 2, 0, 0), mk(32'h704, 0, 1, 2, 0, 0));
        step();
        stall = 1'b1;
        enq(2'b11, mk(32'h710, 0, 1, 2, 0, 0), mk(32'h714, 0, 1, 2, 0, 0));
        enq(2'b11, mk(32'h718, 0, 1, 2, 0, 0), mk(32'h71C, 0, 1, 2, 0, 0));
        enq(2'b01, mk(32'h720, 0, 1, 2, 0, 0), mk(32'h724, 0, 1, 2, 0, 0));
        chk("mid occ", 64'(occupancy), DUAL ? 5 : 6);
        chk("mid valid held", 64'(iss_valid), DUAL ? 3 : 1);
        chk("mid uop0 held", iss_uop0, mk(32'h700, 0, 1, 2, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 64'(iss_valid), 0);
        chk("async rst occ", 64'(occupancy), 0);
        chk("async rst ready", 64'(enq_ready), 1);
        chk("async rst uop0", iss_uop0, 0);
        chk("async rst uop1", iss_uop1, 0);
        step();
        rst = 1'b0;
        stall = 1'b0;
        step();
        chk("post rst valid", 64'(iss_valid), 0);
        chk("post rst occ", 64'(occupancy), 0);
        pair_test("post rst", mk(32'h800, 3, 1, 2, 1, 0), mk(32'h804, 4, 5, 6, 1, 0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue in-order scheduler between decode and the two-lane `ExecuteUnit`.
- Buffers decoded micro-ops in a circular queue.
- Each cycle it selects up to two for lane 0/lane 1.
- It splits pairs with an intra-pair RAW hazard or two control ops.
- It squashes everything on a taken branch or return reported by execute.
- Issue outputs are registered and drive the `ExecuteUnit` operand/control pipeline register.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, at least 4.
- `UOP_W`, 64: micro-op width. Fixed fields:
  - [31:0] pc
  - [35:32] rd
  - [39:36] rs1
  - [43:40] rs2
  - [44] wr_en
  - [45] is_ctrl (branch or ret)
  - [UOP_W-1:46] opaque

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enq_valid` in 2: per-slot enqueue request; slot 0 is older.
- `enq_uop0`, `enq_uop1` in UOP_W: micro-ops for slots 0/1.
- `enq_ready` out 1: high when free entries ≥ 2.
- `flush` in 1: OR of `isBranchTaken1`/`isBranchTaken2` from execute.
- `stall` in 1: downstream hold.
- `iss_valid` out 2: lane valid; bit 0 is lane 0.
- `iss_uop0`, `iss_uop1` out UOP_W: issued micro-ops.
- `occupancy` out $clog2(DEPTH)+1: current entry count.

## Operation
Queue:
- Head/tail pointers wrap modulo DEPTH; `occupancy` counts 0..DEPTH.
- Enqueue occurs only when `enq_ready`=1. `enq_ready` depends on current occupancy only; same-cycle dequeues are not credited.
- `enq_valid`=11 writes slot 0, then slot 1, in order.
- `enq_valid`=01 or 10 writes only the valid slot.
- Enqueue attempted while `enq_ready`=0 is dropped. Decode must hold.

Selection (combinational from queue head, registered into `iss_*`):
- Lane 0 is the head entry, if occupancy ≥ 1.
- Lane 1 is head+1, if occupancy ≥ 2 and all of the following hold:
  - not (head.wr_en and head.rd≠0 and (head.rd==h1.rs1 or head.rd==h1.rs2));
  - not (head.is_ctrl and h1.is_ctrl).
- A control op is allowed on lane 1 only behind a non-control head. Lane 1 is younger, so execute discards it if lane 0 redirects.
- Dequeue count equals the number of lanes selected.
- Lane 1 never issues without lane 0.

Per-edge priority (highest first):
1. `rst`: queue empty, `iss_valid`=00, `iss_uop*`=0, `occupancy`=0.
2. `flush`: queue emptied (pointers equal, occupancy 0), `iss_valid`←00, same-cycle enqueue discarded.
3. `stall`=1: `iss_*` hold, no dequeue, enqueue still permitted.
4. Normal: `iss_*` ← selection (00 if queue empty), dequeue, enqueue.

Simultaneous enqueue and dequeue are supported:
- occupancy_next = occupancy + enq_count − deq_count.
- Occupancy never exceeds DEPTH.

## Timing
- Reset values: `iss_valid`=00, `iss_uop0`=`iss_uop1`=0, `occupancy`=0, `enq_ready`=1.
- Latency: a micro-op enqueued at edge E appears on `iss_*` after edge E+1 at the earliest. There is no bypass around the queue.
- Throughput: 2 micro-ops/cycle without hazards; 1/cycle for fully dependent chains.
- `flush` sampled at edge F: `iss_valid`=00 after F. New enqueues are accepted from edge F+1.
- `rst` asserted mid-operation clears all state immediately, without waiting for a clock edge. Release is synchronized externally.
- `enq_ready` and `occupancy` are combinational from registered state only. There is no input-to-output path.

## Configuration
- `ISSUE_DUAL_EN` defined: dual-issue selection as above.
- `ISSUE_DUAL_EN` undefined: single-issue debug mode.
  - Lane 1 is never selected; `iss_valid[1]` is constant 0 and `iss_uop1` is constant 0.
  - Dequeue is at most 1 per cycle.
  - Enqueue rules are unchanged.

## Test plan
- Reset: assert `rst` mid-stream with occupancy 5 → immediately `iss_valid`=00, `occupancy`=0, `enq_ready`=1.
- Independent pair: enqueue pc 0x0 (rd=1, rs 3/4, wr=1) and pc 0x4 (rd=2, rs 5/6) → next cycle `iss_valid`=11, `iss_uop0`.pc=0x0, `iss_uop1`.pc=0x4, `occupancy`=0.
- RAW split: pc 0x0 rd=5 wr=1, pc 0x4 rs1=5 → cycle 1: `iss_valid`=01 with pc 0x0; cycle 2: `iss_valid`=01, lane 0 pc 0x4. Repeat with rd=0 → `iss_valid`=11 in one cycle.
- Control pair: two is_ctrl ops pc 0x8/0xC → issued on lane 0 in consecutive cycles. Non-ctrl head plus ctrl → 11.
- Full/wrap: `stall`=1, enqueue 4 pairs with DEPTH=8 → `occupancy`=8, `enq_ready`=0, a 5th pair is dropped. Release `stall` → drains 2/cycle in pc order across the pointer wrap; `enq_ready`=1 once occupancy ≤ 6.
- Flush: occupancy 6 plus same-cycle enqueue and `flush`=1 → after the edge `occupancy`=0, `iss_valid`=00, and the enqueued ops are never issued.
